// File: rtl/branch_outcome_queue_if.sv
// Commit-side and predictor-update-side signal bundle for branch_outcome_queue.
// master: the core/predictor side driving commits and accepting outcomes.
// slave:  the queue itself.
interface branch_outcome_queue_if #(
  parameter int AMSB = 31
);
  // Commit bus: four slots per cycle.
  logic [3:0]    cmt_v;
  logic [3:0]    cmt_br;
  logic [3:0]    cmt_takb;
  logic [AMSB:0] cmt_ip [0:3];

  // Predictor update port: valid/ready handshake on the head entry.
  logic          out_valid;
  logic          out_ready;
  logic [AMSB:0] out_ip;
  logic          out_takb;

  modport master (
    output cmt_v, cmt_br, cmt_takb, cmt_ip, out_ready,
    input  out_valid, out_ip, out_takb
  );

  modport slave (
    input  cmt_v, cmt_br, cmt_takb, cmt_ip, out_ready,
    output out_valid, out_ip, out_takb
  );
endinterface

// File: rtl/branch_outcome_queue.sv
// Branch outcome queue: collects conditional-branch outcomes from a 4-wide
// commit stage (stopping at the first taken branch) and replays them in order
// to the branch predictor update port. Entries that do not fit are dropped,
// highest slot first, and counted in a saturating drop counter.
// DEPTH must be a power of two and at least 8.
module branch_outcome_queue #(
  parameter int AMSB  = 31,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  branch_outcome_queue_if.slave  bus,
  output logic                   cmt_stall,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            drop_cnt
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] STALL_C = (PW+1)'(DEPTH - 4);

  typedef struct packed {
    logic          takb;
    logic [AMSB:0] ip;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic [15:0]   r_drop;

  logic [3:0]    w_qual;
  logic [2:0]    w_nqual;
  logic [PW:0]   w_free;
  logic [2:0]    w_nenq;
  logic [2:0]    w_ndrop;
  logic [3:0]    w_wr_en;
  logic [PW-1:0] w_wr_addr [4];
  entry_t        w_wr_data [4];
  logic          w_pop;
  logic [16:0]   w_drop_sum;

  // Qualify slots: conditional branches up to and including the first taken one.
  always_comb begin
    logic blocked;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    w_qual  = '0;
    w_nqual = '0;
    blocked = 1'b0;
    for (int n = 0; n < 4; n++) begin
      w_qual[n] = bus.cmt_v[n] & bus.cmt_br[n] & ~blocked;
      if (w_qual[n]) w_nqual = w_nqual + 3'd1;
      blocked = blocked | (bus.cmt_v[n] & bus.cmt_br[n] & bus.cmt_takb[n]);
    end
  end

  // Admission: only space left by the registered count is usable; a same-cycle pop does not help.
  always_comb begin
    w_free = DEPTH_C - r_count;
    if ((PW+1)'(w_nqual) <= w_free) w_nenq = w_nqual;
    else                            w_nenq = w_free[2:0];
    w_ndrop    = w_nqual - w_nenq;
    w_drop_sum = {1'b0, r_drop} + 17'(w_ndrop);
    w_pop      = (r_count != '0) & bus.out_ready;
  end

  // Compact qualified slots onto consecutive tail entries; the highest ones overflow first.
  always_comb begin
    logic [2:0] k;
    k = '0;
    for (int n = 0; n < 4; n++) begin
      w_wr_en[n]        = 1'b0;
      w_wr_addr[n]      = r_tail + PW'(k);
      w_wr_data[n].takb = bus.cmt_takb[n];
      w_wr_data[n].ip   = bus.cmt_ip[n];
      if (w_qual[n]) begin
        w_wr_en[n] = (k < w_nenq) & ~flush;
        k          = k + 3'd1;
      end
    end
  end

  // Pointer and occupancy state; flush empties the queue and ignores this cycle's traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_nenq);
      r_count <= r_count + (PW+1)'(w_nenq) - (PW+1)'(w_pop);
    end
  end

  // Saturating drop counter; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_drop <= '0;
    else if (!flush) r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  // Entry storage: up to four writes per cycle to distinct consecutive addresses.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; entries are only observed when covered by r_count.
    for (int n = 0; n < 4; n++) begin
      if (w_wr_en[n]) r_mem[w_wr_addr[n]] <= w_wr_data[n];
    end
  end

  assign bus.out_valid = (r_count != '0);
  assign bus.out_ip    = r_mem[r_head].ip;
  assign bus.out_takb  = r_mem[r_head].takb;
  assign cmt_stall     = (r_count > STALL_C);
  assign count         = r_count;
  assign drop_cnt      = r_drop;

endmodule
